// File: rtl/workpiece_counter_mux.sv
// workpiece_counter_mux: multi-channel debounced BCD workpiece counter with a
// multiplexed 7-segment display of one selected channel.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module workpiece_counter_mux #(
    parameter int CHANNELS = 2,
    parameter int DIGITS   = 4,
    parameter int DEB_CYC  = 50000,
    parameter int SCAN_DIV = 20833
) (
    input  logic                                            clk,
    input  logic                                            nCR,
    input  logic [CHANNELS-1:0]                             detector,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
    input  logic                                            clr,
    output logic [6:0]                                      seg,
    output logic [DIGITS-1:0]                               Light,
    output logic [CHANNELS-1:0]                             ovf
);

    localparam int DW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = DIGITS * 4;

    logic [CHANNELS-1:0] sync1, sync2, deb, fall;
    logic [DW-1:0]       dcnt [CHANNELS];
    logic [CW-1:0]       cnt  [CHANNELS];

    logic [SW-1:0] div;
    logic [IW-1:0] idx;
    logic [CW-1:0] snap, sel_cnt;
    logic          snap_dash, sel_bad;
    logic [3:0]    cur_digit;
    logic          blank;
    logic [6:0]    seg_nxt;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic carry;
        logic [3:0] d;
        bcd_inc = v;
        carry   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = v[i*4 +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[i*4 +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic all_nines(input logic [CW-1:0] v);
        all_nines = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] != 4'd9) all_nines = 1'b0;
        end
    endfunction

    // Falling edge of the debounced level: fires in the cycle the level is about to drop
    always_comb begin
        fall = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            fall[ch] = deb[ch] & ~sync2[ch] & (dcnt[ch] == DW'(DEB_CYC - 1));
        end
    end

    // Synchronise and debounce every detector line
    always_ff @(posedge clk) begin
        if (!nCR) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) dcnt[ch] <= '0;
        end else begin
            sync1 <= detector;
            sync2 <= sync1;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                if (sync2[ch] == deb[ch]) begin
                    dcnt[ch] <= '0;
                end else if (dcnt[ch] == DW'(DEB_CYC - 1)) begin
                    deb[ch]  <= sync2[ch];
                    dcnt[ch] <= '0;
                end else begin
                    dcnt[ch] <= dcnt[ch] + DW'(1);
                end
            end
        end
    end

    // BCD counters with sticky overflow; clear of the selected channel beats a count
    always_ff @(posedge clk) begin
        if (!nCR) begin
            ovf <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) cnt[ch] <= '0;
        end else begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                if (clr && (32'(ch_sel) == ch)) begin
                    cnt[ch] <= '0;
                    ovf[ch] <= 1'b0;
                end else if (fall[ch]) begin
                    cnt[ch] <= bcd_inc(cnt[ch]);
                    if (all_nines(cnt[ch])) ovf[ch] <= 1'b1;
                end
            end
        end
    end

    // Select the displayed channel; out-of-range selections flag a dash frame
    always_comb begin
        sel_cnt = '0;
        sel_bad = 1'b1;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (32'(ch_sel) == ch) begin
                sel_cnt = cnt[ch];
                sel_bad = 1'b0;
            end
        end
    end

    // Decode the snapshot digit under the scan index into active-low segments
    always_comb begin
        cur_digit = snap[idx*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx != '0) && ((snap >> {idx, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif
        if (snap_dash) begin
            seg_nxt = 7'h3F;
        end else if (blank) begin
            seg_nxt = 7'h7F;
        end else begin
            case (cur_digit)
                4'd0:    seg_nxt = 7'h40;
                4'd1:    seg_nxt = 7'h79;
                4'd2:    seg_nxt = 7'h24;
                4'd3:    seg_nxt = 7'h30;
                4'd4:    seg_nxt = 7'h19;
                4'd5:    seg_nxt = 7'h12;
                4'd6:    seg_nxt = 7'h02;
                4'd7:    seg_nxt = 7'h78;
                4'd8:    seg_nxt = 7'h00;
                4'd9:    seg_nxt = 7'h10;
                default: seg_nxt = 7'h7F;
            endcase
        end
    end

    // Scan divider and digit index; snapshot taken as the index wraps so a frame is consistent
    always_ff @(posedge clk) begin
        if (!nCR) begin
            div       <= '0;
            idx       <= '0;
            snap      <= '0;
            snap_dash <= 1'b0;
            seg       <= 7'h7F;
            Light     <= '1;
        end else begin
            if (div == SW'(SCAN_DIV - 1)) begin
                div <= '0;
                if (idx == IW'(DIGITS - 1)) begin
                    idx       <= '0;
                    snap      <= sel_cnt;
                    snap_dash <= sel_bad;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                div <= div + SW'(1);
            end
            Light <= ~(DIGITS'(1) << idx);
            seg   <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_workpiece_counter_mux.sv
// Directed bench for workpiece_counter_mux: instance A (3 ch, 4 digits) for
// debounce/carry/clear/scan, instance B (2 ch, 2 digits) for wrap and overflow.
module tb_workpiece_counter_mux;

    localparam int DEB_A = 8;
    localparam int SCAN_A = 4;
    localparam int DEB_B = 4;
    localparam int SCAN_B = 3;

    localparam logic [6:0] GL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       nCR = 1'b0;
    logic [2:0] det_a = '1;
    logic [1:0] sel_a = '0;
    logic       clr_a = 1'b0;
    logic [6:0] seg_a;
    logic [3:0] light_a;
    logic [2:0] ovf_a;
    logic [1:0] det_b = '1;
    logic       sel_b = 1'b0;
    logic       clr_b = 1'b0;
    logic [6:0] seg_b;
    logic [1:0] light_b;
    logic [1:0] ovf_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    workpiece_counter_mux #(.CHANNELS(3), .DIGITS(4), .DEB_CYC(DEB_A), .SCAN_DIV(SCAN_A)) dut_a (
        .clk(clk), .nCR(nCR), .detector(det_a), .ch_sel(sel_a), .clr(clr_a),
        .seg(seg_a), .Light(light_a), .ovf(ovf_a)
    );

    workpiece_counter_mux #(.CHANNELS(2), .DIGITS(2), .DEB_CYC(DEB_B), .SCAN_DIV(SCAN_B)) dut_b (
        .clk(clk), .nCR(nCR), .detector(det_b), .ch_sel(sel_b), .clr(clr_b),
        .seg(seg_b), .Light(light_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int d, input logic dash);
        logic [3:0] dig;
        dig = bcd[d*4 +: 4];
        if (dash) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && (bcd >> (d * 4)) == 16'h0) return 7'h7F;
`endif
        return GL[dig];
    endfunction

    // One detector workpiece: low for 'low' cycles, then high long enough to settle
    task automatic pulse(input int inst, input int ch, input int low);
        @(negedge clk);
        if (inst == 0) det_a[ch] = 1'b0; else det_b[ch] = 1'b0;
        repeat (low) @(negedge clk);
        if (inst == 0) det_a[ch] = 1'b1; else det_b[ch] = 1'b1;
        repeat ((inst == 0 ? DEB_A : DEB_B) + 6) @(negedge clk);
    endtask

    // Wait for a fresh frame, then check Light/seg for every digit slot in order
    task automatic disp(input int inst, input string tag, input logic [15:0] bcd, input logic dash);
        int nd, sd;
        logic [3:0] prev, cur;
        logic found;
        nd = (inst == 0) ? 4 : 2;
        sd = (inst == 0) ? SCAN_A : SCAN_B;
        repeat (nd * sd + 4) @(negedge clk);
        found = 1'b0;
        prev = (inst == 0) ? light_a : {2'b11, light_b};
        for (int i = 0; i < 3 * nd * sd && !found; i++) begin
            @(negedge clk);
            cur = (inst == 0) ? light_a : {2'b11, light_b};
            if (cur == 4'hE && prev != 4'hE) found = 1'b1;
            prev = cur;
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL %s_sync observed=0 expected=1", tag);
        end
        for (int d = 0; d < nd; d++) begin
            logic [3:0] exp_l;
            exp_l = 4'hF & ~(4'h1 << d);
            if (inst == 1) exp_l[3:2] = 2'b11;
            if (inst == 0)
                chk($sformatf("%s_d%0d", tag, d), {21'h0, light_a, seg_a}, {21'h0, exp_l, exp_seg(bcd, d, dash)});
            else
                chk($sformatf("%s_d%0d", tag, d), {21'h0, 2'b11, light_b, seg_b}, {21'h0, exp_l, exp_seg(bcd, d, dash)});
            repeat (sd) @(negedge clk);
        end
    endtask

    initial begin
        // Reset with detectors toggling
        @(negedge clk);
        chk("rst_seg_a", {25'h0, seg_a}, 32'h7F);
        chk("rst_light_a", {28'h0, light_a}, 32'hF);
        chk("rst_ovf_a", {29'h0, ovf_a}, 32'h0);
        det_a = 3'b010; det_b = 2'b01;
        @(negedge clk);
        det_a = 3'b101; det_b = 2'b10;
        @(negedge clk);
        det_a = '1; det_b = '1;
        chk("rst_seg_b", {25'h0, seg_b}, 32'h7F);
        chk("rst_light_b", {30'h0, light_b}, 32'h3);
        chk("rst_ovf_b", {30'h0, ovf_b}, 32'h0);
        nCR = 1'b1;
        disp(0, "rst_cnt0", 16'h0000, 1'b0);

        // Debounce: short glitch ignored, long pulse counted once
        pulse(0, 0, DEB_A - 1);
        disp(0, "glitch", 16'h0000, 1'b0);
        pulse(0, 0, DEB_A + 5);
        disp(0, "deb_one", 16'h0001, 1'b0);

        // BCD carry on channel 1
        for (int i = 0; i < 99; i++) pulse(0, 1, DEB_A + 3);
        sel_a = 2'd1;
        disp(0, "pre99", 16'h0099, 1'b0);
        pulse(0, 1, DEB_A + 3);
        disp(0, "carry100", 16'h0100, 1'b0);
        sel_a = 2'd0;
        disp(0, "ch0_keep", 16'h0001, 1'b0);
        chk("ovf_a_carry", {29'h0, ovf_a}, 32'h0);

        // Clear in the exact cycle the ch0 count pulse is high
        @(negedge clk);
        det_a[0] = 1'b0;
        repeat (DEB_A + 1) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        repeat (4) @(negedge clk);
        det_a[0] = 1'b1;
        repeat (DEB_A + 6) @(negedge clk);
        disp(0, "clr_race", 16'h0000, 1'b0);
        sel_a = 2'd1;
        disp(0, "clr_other", 16'h0100, 1'b0);

        // Scan order and leading digits with 42 on ch0
        for (int i = 0; i < 42; i++) pulse(0, 0, DEB_A + 3);
        sel_a = 2'd0;
        disp(0, "scan42", 16'h0042, 1'b0);
        sel_a = 2'd3;
        disp(0, "dash", 16'h0000, 1'b1);

        // Wrap and sticky overflow on the 2-digit instance
        pulse(1, 1, DEB_B + 3);
        for (int i = 0; i < 100; i++) pulse(1, 0, DEB_B + 3);
        chk("wrap_ovf", {30'h0, ovf_b}, 32'h1);
        disp(1, "wrap00", 16'h0000, 1'b0);
        @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("clr_ovf", {30'h0, ovf_b}, 32'h0);
        sel_b = 1'b1;
        disp(1, "b_ch1", 16'h0001, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
